// File: rtl/sseg_pkg.sv
// Shared constants, state type and helpers for the seven-segment scan driver.
package sseg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_t;

    // Cathode patterns {CG..CA}, active-low, indexed by hex digit value.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Largest value that fits in the given number of decimal digits.
    function automatic logic [63:0] max_decimal(input int digits);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < digits; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
// done is high during the final conversion cycle and bcd then carries the
// finished result, so a consumer can capture it on the same edge busy falls.
module bin2bcd_seq
    import sseg_pkg::*;
#(
    parameter int VALUE_W = 14,
    parameter int DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VALUE_W-1:0]    value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam logic [63:0] MAX_DEC = max_decimal(DIGITS);

    conv_state_t       state;
    conv_state_t       state_next;
    logic [CW-1:0]     cnt;
    logic [VALUE_W-1:0] bin_q;
    logic [BW-1:0]     bcd_q;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     bcd_step;
    logic              ovf_q;
    logic              last;

    assign last = (cnt == CW'(VALUE_W - 1));

    // State register for the conversion FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: a start launches a conversion lasting VALUE_W cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CONV;
            CONV: if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_step = {bcd_adj[BW-2:0], bin_q[VALUE_W-1]};
    end

    // Datapath: load the operand on start, then walk it through the BCD shifter.
    // A bit carried out of the top digit also means the value did not fit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            bin_q <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
        end else if (state == IDLE && start) begin
            cnt   <= '0;
            bin_q <= value;
            bcd_q <= '0;
            ovf_q <= (64'(value) > MAX_DEC);
        end else if (state == CONV) begin
            cnt   <= cnt + 1'b1;
            bin_q <= bin_q << 1;
            bcd_q <= bcd_step;
            ovf_q <= ovf_q | bcd_adj[BW-1];
        end
    end

    assign busy = (state == CONV);
    assign done = (state == CONV) && last;
    assign bcd  = bcd_step;
    assign ovf  = ovf_q;

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment driver: captures a value, shows it as hex or
// decimal from a tear-free display register, and scans the anodes.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int VALUE_W  = 14,
    parameter int TICK_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VALUE_W-1:0]  value,
    input  logic                load,
    input  logic                mode_dec,
    input  logic                blank_lz,
    input  logic [DIGITS-1:0]   dp,
    output logic                busy,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg,
    output logic                dp_n
);

    localparam int NW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]           pre;
    logic                    tick;
    logic [SW-1:0]           scan;
    logic                    accept;
    logic                    conv_busy;
    logic                    conv_done;
    logic                    conv_ovf;
    logic [NW-1:0]           conv_bcd;
    logic [NW-1:0]           hex_digits;
    logic                    cap_blank;
    logic [DIGITS-1:0][3:0]  disp_digits;
    logic                    disp_dash;
    logic                    disp_blank;
    logic [DIGITS-1:0]       digit_dark;
    logic                    all_zero;
    logic [6:0]              seg_next;

    assign tick   = (pre == PW'(TICK_DIV - 1));
    assign accept = load && !conv_busy;
    assign busy   = conv_busy;

    // Hex mode takes the low nibbles of the value, zero-extended when narrow.
    generate
        if (VALUE_W >= NW) begin : g_hex_trunc
            assign hex_digits = value[NW-1:0];
        end else begin : g_hex_ext
            assign hex_digits = {{(NW - VALUE_W){1'b0}}, value};
        end
    endgenerate

    bin2bcd_seq #(
        .VALUE_W (VALUE_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (accept && mode_dec),
        .value (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // Prescaler: free-running 0..TICK_DIV-1, tick marks the wrap cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
    end

    // Scan index steps through the digits once per tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       scan <= '0;
        else if (tick) scan <= (scan == SW'(DIGITS - 1)) ? '0 : scan + 1'b1;
    end

    // Hold the blanking choice of a decimal load until its conversion lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      cap_blank <= 1'b0;
        else if (accept && mode_dec)  cap_blank <= blank_lz;
    end

    // Display register changes only when a complete new image is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_digits <= '0;
            disp_dash   <= 1'b0;
            disp_blank  <= 1'b0;
        end else if (conv_done) begin
            disp_digits <= conv_bcd;
            disp_dash   <= conv_ovf;
            disp_blank  <= cap_blank;
        end else if (accept && !mode_dec) begin
            disp_digits <= hex_digits;
            disp_dash   <= 1'b0;
            disp_blank  <= blank_lz;
        end
    end

    // A digit goes dark when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        all_zero   = 1'b1;
        digit_dark = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero && (disp_digits[i] == 4'd0);
            digit_dark[i] = disp_blank && !disp_dash && all_zero;
        end
    end

    // Pick the cathode pattern for the digit currently being scanned.
    always_comb begin
        seg_next = SEG_HEX[disp_digits[scan]];
        if (disp_dash)             seg_next = SEG_DASH;
        else if (digit_dark[scan]) seg_next = SEG_BLANK;
    end

    // Registered pin drivers so anodes and cathodes switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an   <= '1;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
        end else begin
            an   <= ~(DIGITS'(1) << scan);
            seg  <= seg_next;
            dp_n <= ~dp[scan];
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver with an arithmetic reference model.
module tb_sseg_scan_driver;

    localparam int DIGITS   = 4;
    localparam int VALUE_W  = 14;
    localparam int TICK_DIV = 4;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [VALUE_W-1:0] value = '0;
    logic               load = 1'b0;
    logic               mode_dec = 1'b0;
    logic               blank_lz = 1'b0;
    logic [DIGITS-1:0]  dp = '0;
    logic               busy;
    logic [DIGITS-1:0]  an;
    logic [6:0]         seg;
    logic               dp_n;

    int checks = 0;
    int errors = 0;

    // Reference model state: what is being displayed, as a plain number.
    bit   model_on = 1'b0;
    int   m_cycle;
    int   m_val;
    bit   m_dec;
    bit   m_blank;
    int   m_pend;
    int   pend_val;
    bit   pend_blank;
    int   m_sc;
    logic [DIGITS-1:0] exp_an;
    logic [6:0]        exp_seg;
    logic              exp_dpn;
    logic              exp_busy;

    logic [DIGITS-1:0] seq_an [17];
    logic [6:0]        seq_seg [17];

    sseg_scan_driver #(
        .DIGITS   (DIGITS),
        .VALUE_W  (VALUE_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .mode_dec (mode_dec),
        .blank_lz (blank_lz),
        .dp       (dp),
        .busy     (busy),
        .an       (an),
        .seg      (seg),
        .dp_n     (dp_n)
    );

    always #5 clk = ~clk;

    // Expected cathodes for digit i of the modelled display, from decimal/hex arithmetic.
    function automatic logic [6:0] model_seg(input int i);
        int  d;
        int  p;
        bit  dark;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (m_dec) begin
            if (m_val > 9999) return 7'h3F;
            d    = (m_val / p) % 10;
            dark = m_blank && (i > 0) && (m_val < p);
        end else begin
            d    = (m_val >> (4 * i)) & 15;
            dark = m_blank && (i > 0) && ((m_val >> (4 * i)) == 0);
        end
        return dark ? 7'h7F : HEX_SEG[d];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one load pulse; caller is positioned at a falling edge.
    task automatic applyStimulus(input int v, input bit dec, input bit blk);
        value    = VALUE_W'(v);
        mode_dec = dec;
        blank_lz = blk;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("busy_timeout", busy, 0);
    endtask

    task automatic wait_anode(input int idx);
        logic [DIGITS-1:0] want;
        int n;
        want = ~(DIGITS'(1) << idx);
        n = 0;
        @(negedge clk);
        while (an !== want && n < 2 * DIGITS * TICK_DIV) begin
            @(negedge clk);
            n++;
        end
        checkOutput("anode_reached", an, want);
    endtask

    task automatic check_digit(input string name, input int idx, input logic [6:0] want);
        wait_anode(idx);
        checkOutput(name, seg, want);
    endtask

    // Model: pins after an edge reflect the scan position and display before it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_on = 1'b1;
            m_cycle  = 0;
            m_val    = 0;
            m_dec    = 1'b0;
            m_blank  = 1'b0;
            m_pend   = 0;
            exp_an   = '1;
            exp_seg  = 7'h7F;
            exp_dpn  = 1'b1;
            exp_busy = 1'b0;
        end else begin
            m_sc    = (m_cycle / TICK_DIV) % DIGITS;
            exp_an  = ~(DIGITS'(1) << m_sc);
            exp_seg = model_seg(m_sc);
            exp_dpn = ~dp[m_sc];
            m_cycle++;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_val   = pend_val;
                    m_dec   = 1'b1;
                    m_blank = pend_blank;
                end
            end else if (load) begin
                if (mode_dec) begin
                    m_pend     = VALUE_W;
                    pend_val   = int'(value);
                    pend_blank = blank_lz;
                end else begin
                    m_val   = int'(value);
                    m_dec   = 1'b0;
                    m_blank = blank_lz;
                end
            end
            exp_busy = (m_pend > 0);
        end
    end

    // Compare every pin against the model on each falling edge.
    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("model_an",   an,   exp_an);
            checkOutput("model_seg",  seg,  exp_seg);
            checkOutput("model_dp_n", dp_n, exp_dpn);
            checkOutput("model_busy", busy, exp_busy);
        end
    end

    initial begin
        int n;
        dp = 4'b1111;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Scan sequence straight out of reset.
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            seq_an[k]  = an;
            seq_seg[k] = seg;
        end
        checkOutput("scan_0",  seq_an[0],  4'b1110);
        checkOutput("scan_3",  seq_an[3],  4'b1110);
        checkOutput("scan_4",  seq_an[4],  4'b1101);
        checkOutput("scan_7",  seq_an[7],  4'b1101);
        checkOutput("scan_8",  seq_an[8],  4'b1011);
        checkOutput("scan_12", seq_an[12], 4'b0111);
        checkOutput("scan_16", seq_an[16], 4'b1110);
        checkOutput("zero_d0", seq_seg[0],  7'h40);
        checkOutput("zero_d3", seq_seg[12], 7'h40);

        // Reset in the middle of a scan forces the pins dark at once.
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_an",   an,   4'b1111);
        checkOutput("rst_seg",  seg,  7'h7F);
        checkOutput("rst_dp_n", dp_n, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dp  = 4'b0000;
        repeat (3) @(negedge clk);

        // Decimal 10 with leading-zero blanking.
        applyStimulus(10, 1'b1, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", n, 14);
        check_digit("dec10_d0", 0, 7'h40);
        check_digit("dec10_d1", 1, 7'h79);
        check_digit("dec10_d2", 2, 7'h7F);
        check_digit("dec10_d3", 3, 7'h7F);

        // Hex 2BEF, no conversion.
        applyStimulus(14'h2BEF, 1'b0, 1'b0);
        checkOutput("hex_busy", busy, 1'b0);
        check_digit("hex_d0", 0, 7'h0E);
        check_digit("hex_d1", 1, 7'h06);
        check_digit("hex_d2", 2, 7'h03);
        check_digit("hex_d3", 3, 7'h24);

        // Out-of-range decimal value shows dashes, immune to blanking.
        applyStimulus(12345, 1'b1, 1'b1);
        wait_idle();
        check_digit("ovf_d0", 0, 7'h3F);
        check_digit("ovf_d3", 3, 7'h3F);

        // A load during conversion is dropped; one right after busy falls is taken.
        applyStimulus(9999, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(42, 1'b1, 1'b1);
        wait_idle();
        applyStimulus(42, 1'b1, 1'b1);
        checkOutput("reload_busy", busy, 1'b1);
        checkOutput("hold_9999",   seg,  7'h10);
        wait_idle();
        check_digit("d42_d0", 0, 7'h24);
        check_digit("d42_d1", 1, 7'h19);
        check_digit("d42_d2", 2, 7'h7F);
        check_digit("d42_d3", 3, 7'h7F);

        // Decimal point follows the scanned digit.
        dp = 4'b0100;
        repeat (2) @(negedge clk);
        wait_anode(2);
        checkOutput("dp_on_d2", dp_n, 1'b0);
        wait_anode(0);
        checkOutput("dp_off_d0", dp_n, 1'b1);

        // Reset during a conversion aborts it and clears the display.
        applyStimulus(1234, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("abort_busy_pre", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_idle", busy, 1'b0);
        check_digit("abort_d0", 0, 7'h40);
        check_digit("abort_d3", 3, 7'h40);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
